// File: rtl/div_iter.sv
// div_iter: iterative restoring integer divider, one quotient bit per cycle.
//
// Computes q = a / b (truncating toward zero) and r = a % b (sign follows the
// dividend) for signed or unsigned WIDTH-bit operands. Division by zero takes
// a one-cycle short path that returns q = all ones, r = a and raises dbz.
//
// Handshake (valid/ready style): start is the request and is taken only when
// the block is idle and not presenting a result. busy is high from the cycle
// after acceptance through the done cycle. done pulses for exactly one cycle
// when q/r/dbz have been updated. abort cancels an operation in flight without
// touching q/r/dbz.
//
// Ports:
//   clk      - sole clock, rising edge
//   divrst   - asynchronous active-high reset, clears all state and outputs
//   start    - request a division (sampled only when idle)
//   signdiv  - 1 = signed two's complement, 0 = unsigned (sampled with start)
//   abort    - synchronous cancel while dividing or fixing up
//   a, b     - dividend and divisor (sampled with start)
//   q, r     - registered quotient and remainder, held until next completion
//   busy     - operation in progress (includes the done cycle)
//   done     - one-cycle completion pulse
//   dbz      - divide-by-zero flag, updated together with q/r

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             divrst,
  input  logic             start,
  input  logic             signdiv,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbzp_q, dbzp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             take;
  logic             accept;

  always_comb begin
    // Magnitudes. The most negative value negates to itself, which read as
    // unsigned is exactly its magnitude, so overflow needs no special case.
    a_mag = (signdiv && a[WIDTH-1]) ? -a : a;
    b_mag = (signdiv && b[WIDTH-1]) ? -b : b;

    // The partial remainder is WIDTH+1 bits once shifted. The stored
    // remainder is always < |b|, so only its low WIDTH bits are kept.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    take   = (rem_sh >= {1'b0, bmag_q});
    // When take is set the true difference is < |b|, so WIDTH bits suffice.
    trial  = rem_sh[WIDTH-1:0] - bmag_q;

    // A start seen while done is still high (the cycle the result appears)
    // is not taken; the earliest next accept is the edge after done falls.
    accept = (state_q == S_IDLE) && start && !done_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    araw_d  = araw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbzp_d  = dbzp_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          bmag_d = b_mag;
          quo_d  = a_mag;
          rem_d  = '0;
          araw_d = a;
          negq_d = signdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d = signdiv & a[WIDTH-1];
          busy_d = 1'b1;
          if (b == '0) begin
            dbzp_d  = 1'b1;
            state_d = S_FIX;
          end else begin
            dbzp_d  = 1'b0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = take ? trial : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], take};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (dbzp_q) begin
            q_d   = '1;
            r_d   = araw_q;
            dbz_d = 1'b1;
          end else begin
            q_d   = negq_q ? -quo_q : quo_q;
            r_d   = negr_q ? -rem_q : rem_q;
            dbz_d = 1'b0;
          end
          done_d  = 1'b1;
          // busy stays high through the done cycle and drops in IDLE.
          state_d = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge divrst) begin
    if (divrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      araw_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbzp_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      araw_q  <= araw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbzp_q  <= dbzp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter at WIDTH=32 and WIDTH=8.
// Expected {dbz, q, r} come from an arithmetic reference model and are queued
// when a start is driven, then popped and compared when done is observed.

module tb_div_iter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic divrst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        s32_start, s32_sd, s32_abort;
  logic [31:0] s32_a, s32_b, q32, r32;
  logic        busy32, done32, dbz32;

  logic        s8_start, s8_sd, s8_abort;
  logic [7:0]  s8_a, s8_b, q8, r8;
  logic        busy8, done8, dbz8;

  div_iter #(.WIDTH(32)) u_div32 (
    .clk    (clk),
    .divrst (divrst),
    .start  (s32_start),
    .signdiv(s32_sd),
    .abort  (s32_abort),
    .a      (s32_a),
    .b      (s32_b),
    .q      (q32),
    .r      (r32),
    .busy   (busy32),
    .done   (done32),
    .dbz    (dbz32)
  );

  div_iter #(.WIDTH(8)) u_div8 (
    .clk    (clk),
    .divrst (divrst),
    .start  (s8_start),
    .signdiv(s8_sd),
    .abort  (s8_abort),
    .a      (s8_a),
    .b      (s8_b),
    .q      (q8),
    .r      (r8),
    .busy   (busy8),
    .done   (done8),
    .dbz    (dbz8)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp32_q[$];
  logic [64:0] exp8_q[$];
  logic [31:0] last_q32 = '0;
  logic [31:0] last_r32 = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, q, r}, q truncating toward zero, r taking dividend sign.
  function automatic logic [64:0] model(input int w, input logic [31:0] aa_in,
                                        input logic [31:0] bb_in, input bit sg);
    logic [31:0] m, aa, bb, qv, rv;
    longint      sa, sb, qq, rr;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    aa = aa_in & m;
    bb = bb_in & m;
    if (bb == 32'd0) return {1'b1, m, aa};
    sa = longint'({32'd0, aa});
    sb = longint'({32'd0, bb});
    if (sg && aa[w-1]) sa = sa - (longint'(1) << w);
    if (sg && bb[w-1]) sb = sb - (longint'(1) << w);
    qq = sa / sb;
    rr = sa % sb;
    qv = 32'(qq) & m;
    rv = 32'(rr) & m;
    return {1'b0, qv, rv};
  endfunction

  function automatic logic get_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic get_dbz(input int w);
    return (w == 32) ? dbz32 : dbz8;
  endfunction
  function automatic logic [31:0] get_q(input int w);
    return (w == 32) ? q32 : {24'd0, q8};
  endfunction
  function automatic logic [31:0] get_r(input int w);
    return (w == 32) ? r32 : {24'd0, r8};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int w, input logic [31:0] aa, input logic [31:0] bb,
                       input bit sg, input bit st, input bit ab);
    if (w == 32) begin
      s32_a = aa; s32_b = bb; s32_sd = sg; s32_start = st; s32_abort = ab;
    end else begin
      s8_a = aa[7:0]; s8_b = bb[7:0]; s8_sd = sg; s8_start = st; s8_abort = ab;
    end
  endtask

  task automatic run_div(input int w, input logic [31:0] aa, input logic [31:0] bb,
                         input bit sg, input bit ab_with_start);
    logic [64:0] e;
    int          lat, bcnt, exp_lat;
    bit          seen;
    @(negedge clk);
    drive(w, aa, bb, sg, 1'b1, ab_with_start);
    e = model(w, aa, bb, sg);
    if (w == 32) exp32_q.push_back(e);
    else         exp8_q.push_back(e);
    exp_lat = e[64] ? 1 : w + 1;
    @(posedge clk);
    #1;
    // Operands may change freely once accepted.
    drive(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(negedge clk);
    check_eq("busy_after_accept", 64'(get_busy(w)), 64'd1);
    bcnt = 1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= w + 4; i++) begin
      @(negedge clk);
      if (get_done(w)) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      if (get_busy(w)) bcnt++;
    end
    check_eq("done_latency", 64'(lat), 64'(exp_lat));
    if (w == 32) e = exp32_q.pop_front();
    else         e = exp8_q.pop_front();
    if (seen) begin
      check_eq("busy_cycles", 64'(bcnt), 64'(exp_lat));
      check_eq("q", 64'(get_q(w)), 64'(e[63:32]));
      check_eq("r", 64'(get_r(w)), 64'(e[31:0]));
      check_eq("dbz", 64'(get_dbz(w)), 64'(e[64]));
      check_eq("busy_in_done", 64'(get_busy(w)), 64'd1);
      if (w == 32) begin
        last_q32 = e[63:32];
        last_r32 = e[31:0];
      end
      @(negedge clk);
      check_eq("done_pulse_end", 64'(get_done(w)), 64'd0);
      check_eq("busy_end", 64'(get_busy(w)), 64'd0);
    end
  endtask

  // Start a 32-bit divide, abort at edge k+n, then immediately start another.
  task automatic run_abort(input logic [31:0] aa, input logic [31:0] bb, input int n);
    @(negedge clk);
    drive(32, aa, bb, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(32, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    s32_abort = 1'b1;
    @(posedge clk);
    #1;
    s32_abort = 1'b0;
    check_eq("abort_done", 64'(done32), 64'd0);
    check_eq("abort_busy", 64'(busy32), 64'd0);
    check_eq("abort_q_hold", 64'(q32), 64'(last_q32));
    check_eq("abort_r_hold", 64'(r32), 64'(last_r32));
    run_div(32, 32'd100, 32'd7, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    divrst = 1'b1;
    drive(32, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_q32", 64'(q32), 64'd0);
    check_eq("rst_r32", 64'(r32), 64'd0);
    check_eq("rst_busy32", 64'(busy32), 64'd0);
    check_eq("rst_done32", 64'(done32), 64'd0);
    check_eq("rst_dbz32", 64'(dbz32), 64'd0);
    check_eq("rst_q8", 64'(q8), 64'd0);
    @(negedge clk);
    divrst = 1'b0;

    // Directed 32-bit cases
    run_div(32, 32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_div(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div(32, 32'd5, 32'd0, 1'b0, 1'b0);
    run_div(32, 32'd5, 32'd0, 1'b1, 1'b0);
    run_div(32, 32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);   // abort with start: start wins
    run_div(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div(32, 32'hDEAD_BEEF, 32'h0001_0003, 1'b1, 1'b0);

    // Abort in DIV and in FIX
    run_div(32, 32'd1000, 32'd9, 1'b0, 1'b0);
    run_abort(32'd100, 32'd7, 10);
    run_div(32, 32'hFFFF_F000, 32'd3, 1'b1, 1'b0);
    run_abort(32'd1234, 32'd5, 33);

    // Reset in the middle of a divide
    @(negedge clk);
    drive(32, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(32, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    divrst = 1'b1;
    #1;
    check_eq("midrst_q", 64'(q32), 64'd0);
    check_eq("midrst_r", 64'(r32), 64'd0);
    check_eq("midrst_busy", 64'(busy32), 64'd0);
    check_eq("midrst_done", 64'(done32), 64'd0);
    @(negedge clk);
    divrst = 1'b0;
    last_q32 = '0;
    last_r32 = '0;
    run_div(32, 32'd100, 32'd7, 1'b0, 1'b0);

    // Random 32-bit operations
    for (int i = 0; i < 24; i++) begin
      run_div(32, $urandom, (i % 6 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31),
              1'($urandom_range(0, 1)), 1'b0);
    end

    // WIDTH=8: signed corners, then a wide random sample of signed pairs
    begin
      logic [7:0] av[5];
      logic [7:0] bv[5];
      av = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h01};
      bv = '{8'h80, 8'hFF, 8'h01, 8'h7F, 8'h02};
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          run_div(8, 32'(av[i]), 32'(bv[j]), 1'b1, 1'b0);
    end
    run_div(8, 32'd5, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      run_div(8, 32'($urandom_range(0, 255)), 32'($urandom_range(1, 255)), 1'b1, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      run_div(8, 32'($urandom_range(0, 255)), 32'($urandom_range(1, 255)), 1'b0, 1'b0);
    end

    check_eq("queue32_empty", 64'(exp32_q.size()), 64'd0);
    check_eq("queue8_empty", 64'(exp8_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
